// File: rtl/circuit_result_capture_pkg.sv
// rtl/circuit_result_capture_pkg.sv - shared run defaults and capture state encoding
package circuit_result_capture_pkg;

    localparam int RUN_LEN_DEF = 100;
    localparam int CNT_W_DEF   = 7;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } cap_state_t;

endpackage

// File: rtl/circuit_run_counter.sv
// rtl/circuit_run_counter.sv - saturating enable counter with sync clear and end flag
module circuit_run_counter #(
    parameter int CNT_W = 7,
    parameter int LAST  = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_end
);

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);

    assign at_end = (cnt == LAST_C);

    // Holding at LAST is the freeze point shared with the upstream iteration
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !at_end) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/circuit_result_capture.sv
// rtl/circuit_result_capture.sv - captures the final recurrence result and offers it via valid/ready
module circuit_result_capture
    import circuit_result_capture_pkg::*;
#(
    parameter int W       = 32,
    parameter int RUN_LEN = RUN_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     y,
    input  logic             restart,
    output logic [W-1:0]     res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] run_cnt,
    output logic             drop
);

    cap_state_t state_q;
    cap_state_t state_d;
    logic       at_end;
    logic       capture;
    logic       drop_set;

    circuit_run_counter #(
        .CNT_W (CNT_W),
        .LAST  (RUN_LEN - 1)
    ) u_run_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (restart),
        .inc    (en && (state_q == ST_RUN)),
        .cnt    (run_cnt),
        .at_end (at_end)
    );

    assign busy = (state_q == ST_RUN);

    // Restart always dominates: it beats a same-cycle capture and aborts a pending result
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        drop_set = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!restart && en && at_end) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (restart) begin
                    drop_set = 1'b1;
                    state_d  = ST_RUN;
                end else if (res_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (restart) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            res_data  <= '0;
            res_valid <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_valid <= (state_d == ST_HOLD);
            drop      <= drop | drop_set;
            if (capture) begin
                res_data <= y;
            end
        end
    end

endmodule

// File: tb/tb_circuit_result_capture.sv
// tb/tb_circuit_result_capture.sv - directed bench with a behavioural run/hold/consume model
module tb_circuit_result_capture;

    localparam int W       = 32;
    localparam int RUN_LEN = 100;
    localparam int CNT_W   = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [W-1:0]     y;
    logic             restart;
    logic [W-1:0]     res_data;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic [CNT_W-1:0] run_cnt;
    logic             drop;

    circuit_result_capture #(
        .W       (W),
        .RUN_LEN (RUN_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .y         (y),
        .restart   (restart),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .run_cnt   (run_cnt),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Model: how many enables have been seen this run, whether a result is pending or consumed
    int           m_enables;
    bit           m_pending;
    bit           m_consumed;
    bit           m_drop;
    logic [W-1:0] m_data;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic e, input logic [W-1:0] yy, input logic rs,
                              input logic rd, input logic r);
        if (r) begin
            m_enables = 0; m_pending = 0; m_consumed = 0; m_drop = 0; m_data = '0;
        end else if (rs) begin
            if (m_pending) m_drop = 1;
            m_pending = 0; m_consumed = 0; m_enables = 0;
        end else if (m_pending) begin
            if (rd) begin
                m_pending = 0;
                m_consumed = 1;
            end
        end else if (!m_consumed && e) begin
            if (m_enables + 1 == RUN_LEN) begin
                m_data = yy;
                m_pending = 1;
            end else begin
                m_enables++;
            end
        end
    endtask

    task automatic cyc(input logic e, input logic [W-1:0] yy, input logic rs,
                       input logic rd, input logic r);
        en = e; y = yy; restart = rs; res_ready = rd; rst = r;
        @(posedge clk);
        model_step(e, yy, rs, rd, r);
        #2;
    endtask

    task automatic run_en(input int n, input logic [W-1:0] ybase);
        for (int k = 0; k < n; k++) cyc(1'b1, ybase + W'(k), 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_valid", W'(res_valid), W'(m_pending));
            check("cyc_data",  res_data, m_data);
            check("cyc_busy",  W'(busy), W'(!m_pending && !m_consumed));
            check("cyc_cnt",   W'(run_cnt), W'(m_enables));
            check("cyc_drop",  W'(drop), W'(m_drop));
        end
    end

    initial begin
        en = 0; y = '0; restart = 0; res_ready = 0; rst = 1;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk_on = 1'b1;
        check("rst_valid", W'(res_valid), 0);
        check("rst_cnt",   W'(run_cnt), 0);
        check("rst_busy",  W'(busy), 1);

        // 1: straight run of 100 enables
        run_en(99, 32'h100);
        check("t1_pre_valid", W'(res_valid), 0);
        cyc(1'b1, 32'h163, 1'b0, 1'b0, 1'b0);
        check("t1_valid", W'(res_valid), 1);
        check("t1_data",  res_data, 32'h163);
        check("t1_model", m_data, 32'h163);
        check("t1_cnt",   W'(run_cnt), 99);
        check("t1_busy",  W'(busy), 0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 2: alternating enable, capture on cycle 198
        for (int c = 0; c < 200; c++) begin
            cyc(c[0] == 1'b0, W'(c), 1'b0, 1'b0, 1'b0);
            if (c == 196) check("t2_cnt99", W'(run_cnt), 99);
            if (c == 197) check("t2_cnt_hold", W'(run_cnt), 99);
            if (c == 197) check("t2_novalid", W'(res_valid), 0);
        end
        check("t2_data", res_data, 32'd198);

        // 3: hold with no ready, then consume
        for (int c = 0; c < 10; c++) cyc(c[0], 32'hDEAD0000 + W'(c), 1'b0, 1'b0, 1'b0);
        check("t3_held", res_data, 32'd198);
        check("t3_valid", W'(res_valid), 1);
        cyc(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
        check("t3_consumed", W'(res_valid), 0);
        run_en(5, 32'h777);
        check("t3_done_data", res_data, 32'd198);
        check("t3_drop", W'(drop), 0);

        // 4: restart from DONE, second run
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("t4_cnt0", W'(run_cnt), 0);
        check("t4_busy", W'(busy), 1);
        run_en(99, 32'h0);
        cyc(1'b1, 32'hABC, 1'b0, 1'b0, 1'b0);
        check("t4_data", res_data, 32'hABC);

        // 5: restart while holding drops the result
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t5_drop", W'(drop), 1);
        check("t5_valid", W'(res_valid), 0);
        check("t5_busy", W'(busy), 1);
        run_en(100, 32'h900);
        check("t5_data", res_data, 32'h963);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t5_drop_sticky", W'(drop), 1);

        // restart coinciding with the final enable must not capture
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        run_en(99, 32'h0);
        cyc(1'b1, 32'h1234, 1'b1, 1'b0, 1'b0);
        check("rc_novalid", W'(res_valid), 0);
        check("rc_cnt0", W'(run_cnt), 0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t5_drop_clr", W'(drop), 0);

        // 6: reset on the 50th enable, then a full run is needed
        run_en(49, 32'h0);
        cyc(1'b1, 32'hFFFF, 1'b0, 1'b0, 1'b1);
        check("t6_cnt",   W'(run_cnt), 0);
        check("t6_data",  res_data, 0);
        check("t6_valid", W'(res_valid), 0);
        check("t6_busy",  W'(busy), 1);
        run_en(99, 32'h0);
        check("t6_nocap", W'(res_valid), 0);
        cyc(1'b1, 32'hCAFE, 1'b0, 1'b0, 1'b0);
        check("t6_cap", res_data, 32'hCAFE);
        check("t6_valid2", W'(res_valid), 1);

        @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
